// File: rtl/freq_div_pkg.sv
// freq_div_pkg: shared state encoding, limits and ratio-legality helper for the divider controller
package freq_div_pkg;
  typedef enum logic [1:0] {IDLE, RUN, SWITCH} state_t;
  localparam int MIN_DIV = 2;
  function automatic logic div_legal(input int n, input int max_div);
    return n >= MIN_DIV && n <= max_div;
  endfunction
endpackage

// File: rtl/freq_div_core.sv
// freq_div_core: period counter and same-cycle div_clk/tick decode
module freq_div_core #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             load,
  input  logic [WIDTH-1:0] load_div,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap,
  output logic             div_clk,
  output logic             tick
);
  assign wrap    = run && cnt == load_div - WIDTH'(1);
  assign div_clk = run && cnt < (load_div >> 1);
  assign tick    = run && cnt == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else        cnt <= (!run || load || wrap) ? '0 : cnt + WIDTH'(1);
endmodule

// File: rtl/freq_div_ctrl.sv
// freq_div_ctrl: programmable divider FSM; ratio changes and stops land only on period boundaries
module freq_div_ctrl
  import freq_div_pkg::*;
#(
  parameter int MAX_DIV = 256,
  parameter int WIDTH   = $clog2(MAX_DIV + 1),
  parameter int DEF_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             div_clk,
  output logic             tick,
  output logic [WIDTH-1:0] cur_div,
  output logic             busy
);
  state_t           state, state_n;
  logic [WIDTH-1:0] pend_div, cnt;
  logic             wrap, accept, ok, apply;
  assign cfg_ready = state != SWITCH;
  assign busy      = state != IDLE;
  assign accept    = cfg_valid && cfg_ready;
  assign ok        = accept && div_legal(int'(cfg_div), MAX_DIV);
  assign apply     = state == SWITCH && wrap;
  always_comb begin
    state_n = state;
    state_n = state == IDLE   ? (en ? RUN : IDLE) :
              wrap && !en     ? IDLE :
              state == SWITCH ? (wrap ? RUN : SWITCH) :
              ok              ? SWITCH : RUN;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      cur_div  <= WIDTH'(DEF_DIV);
      pend_div <= '0;
      cfg_err  <= 1'b0;
    end else begin
      state    <= state_n;
      cfg_err  <= accept && !ok;
      // a legal ratio that ends up in IDLE takes effect at once; otherwise it waits for the boundary
      cur_div  <= apply ? pend_div : (ok && state_n == IDLE) || (ok && state == IDLE) ? cfg_div : cur_div;
      pend_div <= ok && state_n == SWITCH ? cfg_div : pend_div;
    end
  freq_div_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (busy),
    .load     (apply),
    .load_div (cur_div),
    .cnt      (cnt),
    .wrap     (wrap),
    .div_clk  (div_clk),
    .tick     (tick)
  );
endmodule

// File: tb/tb_freq_div_ctrl.sv
// tb_freq_div_ctrl: randomized bench against a period-level reference model
module tb_freq_div_ctrl;
  localparam int MAX_DIV = 256;
  localparam int WIDTH   = 9;
  localparam int DEF_DIV = 4;
  logic clk = 0, rst_n, en, cfg_valid;
  logic [WIDTH-1:0] cfg_div, cur_div;
  logic cfg_ready, cfg_err, div_clk, tick, busy;
  int n_chk = 0, n_err = 0;
  bit m_run, m_err;
  int m_phase, m_ratio, m_pend;
  logic last_dc, last_tick;
  always #5 clk = ~clk;
  freq_div_ctrl #(.MAX_DIV(MAX_DIV), .WIDTH(WIDTH), .DEF_DIV(DEF_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .div_clk(div_clk), .tick(tick),
    .cur_div(cur_div), .busy(busy)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit legal(input int d);
    return d >= 2 && d <= MAX_DIV;
  endfunction
  task automatic model_reset;
    m_run = 0; m_err = 0; m_phase = 0; m_ratio = DEF_DIV; m_pend = -1;
  endtask
  task automatic model_step;
    bit acc, good;
    acc  = cfg_valid && m_pend < 0;
    good = acc && legal(int'(cfg_div));
    m_err = acc && !good;
    if (!m_run) begin
      if (good) m_ratio = int'(cfg_div);
      if (en) begin m_run = 1; m_phase = 0; end
    end else if (m_phase == m_ratio - 1) begin
      if (m_pend >= 0) begin m_ratio = m_pend; m_pend = -1; end
      m_phase = 0;
      if (!en) m_run = 0;
      if (good) begin
        if (m_run) m_pend = int'(cfg_div);
        else m_ratio = int'(cfg_div);
      end
    end else begin
      m_phase++;
      if (good) m_pend = int'(cfg_div);
    end
  endtask
  task automatic check_all;
    chk("tick", tick, m_run && m_phase == 0);
    chk("div_clk", div_clk, m_run && m_phase < m_ratio / 2);
    chk("busy", busy, m_run);
    chk("cfg_ready", cfg_ready, m_pend < 0);
    chk("cur_div", cur_div, m_ratio);
    chk("cfg_err", cfg_err, m_err);
  endtask
  task automatic cycle(input logic e, input logic v, input logic [WIDTH-1:0] d);
    en = e; cfg_valid = v; cfg_div = d;
    @(negedge clk);
    check_all();
    last_dc = div_clk; last_tick = tick;
    @(posedge clk);
    model_step();
    #1;
  endtask
  function automatic logic [WIDTH-1:0] rand_div;
    int r;
    r = $urandom_range(0, 19);
    return r == 0 ? WIDTH'(0) : r == 1 ? WIDTH'(1) : r == 2 ? WIDTH'(300) :
           r == 3 ? WIDTH'(256) : r == 4 ? WIDTH'(257) : WIDTH'($urandom_range(2, 9));
  endfunction
  initial begin
    logic seq [8] = '{1, 1, 0, 0, 1, 1, 0, 0};
    int k;
    rst_n = 0; en = 0; cfg_valid = 0; cfg_div = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    cycle(0, 0, '0);
    for (int i = 0; i < 9; i++) begin
      cycle(1, 0, '0);
      if (i > 0) chk("p1_div_clk", last_dc, seq[i-1]);
      if (i > 0) chk("p1_tick", last_tick, i == 1 || i == 5);
    end
    for (int i = 0; i < 4000; i++)
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0, rand_div());
    k = 0;
    while (m_pend < 0 && k < 50) begin
      cycle(1, 1, WIDTH'(5 + k % 3));
      k++;
    end
    chk("switch_reached", m_pend >= 0, 1);
    #1 rst_n = 0;
    #1;
    chk("rst_div_clk", div_clk, 0);
    chk("rst_tick", tick, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_cur_div", cur_div, DEF_DIV);
    chk("rst_cfg_err", cfg_err, 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 20; i++) cycle(1, 0, '0);
    for (int i = 0; i < 1000; i++)
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0, rand_div());
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/freq_div_ctrl.md
Name: freq_div_ctrl

Overview:
Run-time programmable clock-divider controller for the frequency-divider datapath. It accepts divide ratios over a valid/ready config port and gates divider start/stop with an enable. Ratio changes and stops take effect only at output-period boundaries, so downstream logic never sees a runt or stretched pulse. It produces a divided clock-like signal plus a single-cycle tick enable, both in the clk domain, posedge only.

Parameters:
MAX_DIV, 256, largest legal divide ratio
WIDTH, $clog2(MAX_DIV+1), width of ratio and counter fields
DEF_DIV, 4, ratio loaded at reset; must satisfy 2 <= DEF_DIV <= MAX_DIV

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
en  in  1  run request; level-sensitive
cfg_valid  in  1  new ratio offered
cfg_div  in  WIDTH  requested ratio N
cfg_ready  out  1  controller can accept cfg
cfg_err  out  1  one-cycle pulse: last accepted cfg_div was illegal
div_clk  out  1  divided output, period N clk cycles
tick  out  1  one-cycle pulse at the start of each div_clk period
cur_div  out  WIDTH  ratio currently in effect
busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE, cnt=0, cur_div=DEF_DIV, pend_div=0, div_clk=0, tick=0, cfg_err=0, busy=0, cfg_ready=1.
- States: IDLE, RUN, SWITCH. SWITCH means a config change is pending.
- IDLE: cnt held at 0; div_clk=0; tick=0. If en is sampled 1, the next state is RUN with cnt=0.
- RUN/SWITCH counting: cnt increments each cycle and wraps from cur_div-1 to 0. Boundary = cycle with cnt==cur_div-1.
- Output decode, in the same cycle as cnt:
  - div_clk=1 iff cnt < (cur_div>>1). High floor(N/2) cycles, low ceil(N/2) cycles.
  - tick=1 iff cnt==0.
  - Both outputs are 0 in IDLE.
- Latency: first tick and div_clk high occur in the first cycle after en is sampled 1 in IDLE.
- en=0 in RUN: the current period completes; at the boundary the next state is IDLE. If en returns to 1 before the boundary, the block stays in RUN with no disturbance.
- Config handshake: transfer occurs on cfg_valid & cfg_ready. cfg_ready=1 in IDLE and RUN, and 0 in SWITCH.
- Legal N: 2 <= N <= MAX_DIV. N of 0, 1, or >MAX_DIV is accepted (consumed), pulses cfg_err the next cycle, and changes nothing else.
- Legal N in IDLE: cur_div <= N on the next cycle. If en=1 in the same cycle, RUN starts with the new N.
- Legal N in RUN: pend_div <= N and the next state is SWITCH.
  - At the boundary: cur_div <= pend_div, cnt <= 0, and the next state is RUN (or IDLE if en=0).
- Legal N accepted in the boundary cycle itself: goes to SWITCH and applies at the next boundary. The old period is not cut.
- N equal to cur_div is treated as a normal change. It is harmless and produces no glitch.
- A reset mid-period forces all outputs to 0 immediately. A truncated div_clk pulse is acceptable only on reset.
- cnt never exceeds cur_div-1. cur_div is never illegal.

Decomposition:
- Package freq_div_pkg:
  - state enum typedef {IDLE, RUN, SWITCH}
  - localparam MIN_DIV=2
  - ratio-legality function
- Sub-module freq_div_core:
  - Inputs: clk, rst_n, run, load, load_div.
  - Outputs: cnt, wrap, div_clk, tick.
  - Holds cnt and the output decode.
- freq_div_ctrl holds the FSM, pend_div, cur_div, the handshake, and cfg_err.

Test Plan:
1. Reset, then en=1, no cfg → cur_div=4. Cycles 1..8 after en: div_clk 1,1,0,0,1,1,0,0; tick at 1 and 5; busy=1.
2. In IDLE, cfg_div=5 accepted, then en=1 → div_clk high 2 and low 3 cycles, repeating; tick every 5 cycles; cur_div=5.
3. Running N=4, cfg_div=6 accepted at cnt=1 → cfg_ready=0 for cnt 2,3. The first 6-cycle period starts exactly after cnt=3; cur_div changes in that cycle; no shortened period.
4. cfg_div=1, then cfg_div=300 (MAX_DIV=256) → each is consumed; cfg_err pulses one cycle after each; cur_div and div_clk phase are unchanged.
5. Running N=4, en=0 at cnt=1 → period finishes (cnt 2,3), then IDLE with div_clk=0 and busy=0. Separately, en=0 then en=1 before the boundary → no gap in ticks.
6. Assert rst_n=0 at cnt=1 while in SWITCH → outputs are 0 immediately. After release: cur_div=DEF_DIV, cfg_ready=1, pending ratio discarded.
